ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
//  Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in a multi-cycle sequence.
//  Stalls the pipeline via stall_req_o and returns a registered write-back (wd/wreg/wdata).
//  Generalised in datapath width and in bits retired per cycle (throughput/area trade).
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  1   quotient/multiplier bits per CALC cycle; 1, 2 or 4; must divide XLEN
//  REG_ADDR_W      5   destination register address width
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           reset, synchronous, active-high
//  start_i      in   1           issue op this cycle (sampled only in IDLE)
//  flush_i      in   1           abort in-flight op (branch mispredict)
//  op_i         in   3           funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  reg1_i       in   XLEN        rs1 value (dividend / multiplicand)
//  reg2_i       in   XLEN        rs2 value (divisor / multiplier)
//  wd_i         in   REG_ADDR_W  destination register
//  wreg_i       in   1           write-enable for destination
//  busy_o       out  1           state != IDLE
//  stall_req_o  out  1           hold IF/ID/EX; combinational
//  done_o       out  1           one-cycle pulse: wdata_o/wd_o/wreg_o valid
//  wd_o         out  REG_ADDR_W  registered destination
//  wreg_o       out  1           registered write-enable; high only with done_o
//  wdata_o      out  XLEN        registered result
// BEHAVIOUR
//  Reset: state=IDLE; busy_o, done_o, wreg_o = 0; wd_o = 0; wdata_o = 0; internal regs cleared.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start_i & !flush_i -> latch op, wd, wreg, abs operands, result signs; go to CALC.
//         Fast path (div ops only): divisor==0 or signed overflow -> DONE directly.
//   CALC: N = XLEN/BITS_PER_CYCLE cycles; down-counter; iter_cnt==0 -> FIX.
//         MUL*: shift-add of |a|*|b| into a 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
//         DIV*/REM*: restoring division, BITS_PER_CYCLE quotient bits per cycle.
//   FIX: apply sign corrections and select result -> DONE.
//   DONE: done_o=1 for one cycle, wreg_o=wreg & (wd!=0) -> IDLE.
//  Latency: start cycle t; done_o at t+N+2 (N+2 stall cycles); fast path done_o at t+1.
//   wdata_o holds its value until the next done_o.
//  stall_req_o = (IDLE & start_i & !flush_i) | CALC | FIX; low in DONE so the pipeline advances.
//  Signedness: MULH s*s; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
//  MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
//  Quotient negative iff signs differ (signed DIV); remainder takes dividend sign.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
//  Overflow (DIV, rs1=MIN, rs2=-1): quotient = MIN; REM = 0.
//  start_i while busy: ignored, no queueing.
//  Flush in any state: next state IDLE; no done_o for the aborted op; wreg_o=0.
//   Flush in the same cycle as start_i in IDLE: op not accepted.
//  rst mid-operation: IDLE next edge; all outputs return to their reset values.
//  wd_i==0 or wreg_i==0: op still runs full latency; done_o pulses; wreg_o=0.
// TESTING
//  MUL 7*-3 (XLEN=32, BPC=1): done_o at t+34, wdata_o=0xFFFFFFEB, wreg_o=1.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV x/0 -> 0xFFFFFFFF at t+1; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//  flush_i at CALC cycle 10 -> IDLE next cycle, no done_o; new start then completes normally.
//  Sweep BPC=2,4 with random ops vs reference model; latency N+2; start while busy ignored; rst mid-CALC clears.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by shift-add of operand magnitudes and divides by restoring
// division, retiring BITS_PER_CYCLE bits per CALC cycle. Signs are applied
// in FIX, and the result is returned as a registered write-back in DONE.
// Divide-by-zero and signed overflow skip the iteration entirely.
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  busy_o,
  output logic                  stall_req_o,
  output logic                  done_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o
);

  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]  iter_cnt;
  logic [2:0]        op_q;
  logic              wreg_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  // Multiply: {running high half, unconsumed multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]   opnd_q;

  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              div_ovf;
  logic              fast_path;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN-1:0]   fast_result;

  logic [XLEN+BITS_PER_CYCLE-1:0] mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN-1:0]   div_rem;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] calc_next;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_result;

  wire accept = (state == IDLE) && start_i && !flush_i;

  // Decode operand signedness from funct3, take magnitudes, and work out the early-out result.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2: a_signed = 1'b1;
      default: ;
    endcase
    a_neg     = a_signed & reg1_i[XLEN-1];
    b_neg     = b_signed & reg2_i[XLEN-1];
    a_abs     = a_neg ? -reg1_i : reg1_i;
    b_abs     = b_neg ? -reg2_i : reg2_i;
    div_zero  = (reg2_i == '0);
    div_ovf   = b_signed & (reg1_i == INT_MIN) & (reg2_i == '1);
    fast_path = op_i[2] & (div_zero | div_ovf);
    if (div_zero) begin
      fast_result = op_i[1] ? reg1_i : '1;
    end else begin
      fast_result = op_i[1] ? '0 : reg1_i;
    end
  end

  // One multiply step: add multiplicand times the low multiplier bits into the high half, then shift right.
  always_comb begin
    mul_sum = {{BITS_PER_CYCLE{1'b0}}, acc[2*XLEN-1:XLEN]};
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (acc[j]) begin
        mul_sum = mul_sum + ({{BITS_PER_CYCLE{1'b0}}, opnd_q} << j);
      end
    end
    mul_next = {mul_sum, acc[XLEN-1:BITS_PER_CYCLE]};
  end

  // One divide step: BITS_PER_CYCLE rounds of shift, trial subtract, restore on borrow.
  always_comb begin
    div_rem   = acc[2*XLEN-1:XLEN];
    div_quo   = acc[XLEN-1:0];
    div_trial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      div_trial = {div_rem, div_quo[XLEN-1]};
      div_quo   = {div_quo[XLEN-2:0], 1'b0};
      if (div_trial >= {1'b0, opnd_q}) begin
        div_trial  = div_trial - {1'b0, opnd_q};
        div_quo[0] = 1'b1;
      end
      div_rem = div_trial[XLEN-1:0];
    end
    div_next  = {div_rem, div_quo};
    calc_next = op_q[2] ? div_next : mul_next;
  end

  // Apply the sign corrections to the magnitude result and pick the half or remainder the op wants.
  always_comb begin
    prod = neg_res_q ? -acc : acc;
    quo  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_result = op_q[1] ? rem : quo;
    end else begin
      fix_result = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a flush overrides everything and returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_i && !flush_i) begin
          next_state = fast_path ? DONE : CALC;
        end
      end
      CALC: begin
        if (iter_cnt == '0) begin
          next_state = FIX;
        end
      end
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush_i) begin
      next_state = IDLE;
    end
  end

  // Status and write-back strobes derived from the current state.
  always_comb begin
    busy_o      = 1'b0;
    stall_req_o = 1'b0;
    done_o      = 1'b0;
    wreg_o      = 1'b0;
    busy_o      = (state != IDLE);
    stall_req_o = accept || (state == CALC) || (state == FIX);
    done_o      = (state == DONE);
    wreg_o      = (state == DONE) && wreg_q && (wd_o != '0);
  end

  // Latch the op on issue, iterate in CALC, and capture the result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt  <= '0;
      op_q      <= '0;
      wreg_q    <= 1'b0;
      wd_o      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc       <= '0;
      opnd_q    <= '0;
      wdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= op_i;
            wreg_q    <= wreg_i;
            wd_o      <= wd_i;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            iter_cnt  <= CNT_LAST;
            if (op_i[2]) begin
              acc    <= {{XLEN{1'b0}}, a_abs};
              opnd_q <= b_abs;
            end else begin
              acc    <= {{XLEN{1'b0}}, b_abs};
              opnd_q <= a_abs;
            end
            if (fast_path) begin
              wdata_o <= fast_result;
            end
          end
        end
        CALC: begin
          if (!flush_i) begin
            acc      <= calc_next;
            iter_cnt <= iter_cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush_i) begin
            wdata_o <= fix_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit: one instance at 1 bit per cycle and
// one at 4 bits per cycle share the same stimulus, and every result, latency,
// stall length and write-back strobe is compared against hand-computed values.
module tb_ex_muldiv_unit;

  localparam int N1 = 32;
  localparam int N4 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;

  logic        busy1, stall1, done1, wreg1_o;
  logic [4:0]  wd1_o;
  logic [31:0] wdata1;
  logic        busy4, stall4, done4, wreg4_o;
  logic [4:0]  wd4_o;
  logic [31:0] wdata4;

  int checks = 0;
  int failures = 0;

  int          lat1, lat4, stl1, stl4, pls1, pls4;
  logic [31:0] res1, res4;
  logic        wro1, wro4;
  logic [4:0]  wdo1, wdo4;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
    logic [4:0]  wd;
    logic        wreg;
  } vec_t;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .REG_ADDR_W(5)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .flush_i(flush), .op_i(op),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .busy_o(busy1), .stall_req_o(stall1), .done_o(done1),
    .wd_o(wd1_o), .wreg_o(wreg1_o), .wdata_o(wdata1)
  );

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .flush_i(flush), .op_i(op),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .busy_o(busy4), .stall_req_o(stall4), .done_o(done4),
    .wd_o(wd4_o), .wreg_o(wreg4_o), .wdata_o(wdata4)
  );

  always #5 clk = ~clk;

  // Issue one op, scramble the inputs afterwards, and record what each instance returns over 40 cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic we);
    @(negedge clk);
    op = o; reg1 = a; reg2 = b; wd = d; wreg = we; start = 1'b1;
    #1;
    lat1 = -1; lat4 = -1; pls1 = 0; pls4 = 0;
    res1 = '0; res4 = '0; wro1 = 1'b0; wro4 = 1'b0; wdo1 = '0; wdo4 = '0;
    stl1 = stall1 ? 1 : 0;
    stl4 = stall4 ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0; op = ~o; reg1 = ~a; reg2 = ~b; wd = ~d; wreg = ~we;
      #1;
      if (stall1) stl1++;
      if (stall4) stl4++;
      if (done1) begin
        pls1++;
        if (lat1 < 0) begin lat1 = k; res1 = wdata1; wro1 = wreg1_o; wdo1 = wd1_o; end
      end
      if (done4) begin
        pls4++;
        if (lat4 < 0) begin lat4 = k; res4 = wdata4; wro4 = wreg4_o; wdo4 = wd4_o; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; reg1 = '0; reg2 = '0; wd = '0; wreg = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy1, stall1, done1, wreg1_o, wd1_o, wdata1} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL reset_bpc1: got busy=%b stall=%b done=%b wreg=%b wd=%h wdata=%h want all zero",
               busy1, stall1, done1, wreg1_o, wd1_o, wdata1);
    end
    checks++;
    if ({busy4, stall4, done4, wreg4_o, wd4_o, wdata4} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL reset_bpc4: got busy=%b stall=%b done=%b wreg=%b wd=%h wdata=%h want all zero",
               busy4, stall4, done4, wreg4_o, wd4_o, wdata4);
    end
  endtask

  task automatic test_multiply();
    vec_t v[10];
    int   e1, e4;
    logic ew;
    v[0] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 5'd5,  1'b1};
    v[1] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 5'd6,  1'b1};
    v[2] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5'd7,  1'b1};
    v[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd8,  1'b1};
    v[4] = '{3'd2, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 1'b0, 5'd9,  1'b1};
    v[5] = '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 5'd10, 1'b1};
    v[6] = '{3'd3, 32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 5'd11, 1'b1};
    v[7] = '{3'd1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 1'b0, 5'd12, 1'b1};
    v[8] = '{3'd0, 32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, 5'd0,  1'b1};
    v[9] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd13, 1'b0};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].wd, v[i].wreg);
      e1 = v[i].fast ? 1 : N1 + 2;
      e4 = v[i].fast ? 1 : N4 + 2;
      ew = v[i].wreg && (v[i].wd != 5'd0);
      checks++; if (res1 !== v[i].exp) begin failures++; $display("[TB] FAIL mul[%0d] data bpc1: got %h want %h", i, res1, v[i].exp); end
      checks++; if (res4 !== v[i].exp) begin failures++; $display("[TB] FAIL mul[%0d] data bpc4: got %h want %h", i, res4, v[i].exp); end
      checks++; if (lat1 != e1) begin failures++; $display("[TB] FAIL mul[%0d] latency bpc1: got %0d want %0d", i, lat1, e1); end
      checks++; if (lat4 != e4) begin failures++; $display("[TB] FAIL mul[%0d] latency bpc4: got %0d want %0d", i, lat4, e4); end
      checks++; if (stl1 != e1) begin failures++; $display("[TB] FAIL mul[%0d] stall bpc1: got %0d want %0d", i, stl1, e1); end
      checks++; if (stl4 != e4) begin failures++; $display("[TB] FAIL mul[%0d] stall bpc4: got %0d want %0d", i, stl4, e4); end
      checks++; if (wro1 !== ew) begin failures++; $display("[TB] FAIL mul[%0d] wreg bpc1: got %b want %b", i, wro1, ew); end
      checks++; if (wro4 !== ew) begin failures++; $display("[TB] FAIL mul[%0d] wreg bpc4: got %b want %b", i, wro4, ew); end
      checks++; if (wdo1 !== v[i].wd) begin failures++; $display("[TB] FAIL mul[%0d] wd bpc1: got %0d want %0d", i, wdo1, v[i].wd); end
      checks++; if (wdo4 !== v[i].wd) begin failures++; $display("[TB] FAIL mul[%0d] wd bpc4: got %0d want %0d", i, wdo4, v[i].wd); end
      checks++; if (pls1 != 1) begin failures++; $display("[TB] FAIL mul[%0d] pulses bpc1: got %0d want 1", i, pls1); end
      checks++; if (pls4 != 1) begin failures++; $display("[TB] FAIL mul[%0d] pulses bpc4: got %0d want 1", i, pls4); end
    end
  endtask

  task automatic test_divide();
    vec_t v[16];
    int   e1, e4;
    v[0]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 5'd1,  1'b1};
    v[1]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 5'd2,  1'b1};
    v[2]  = '{3'd5, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 5'd3,  1'b1};
    v[3]  = '{3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 5'd4,  1'b1};
    v[4]  = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 5'd5,  1'b1};
    v[5]  = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 5'd6,  1'b1};
    v[6]  = '{3'd4, 32'h80000000, 32'h00000002, 32'hC0000000, 1'b0, 5'd7,  1'b1};
    v[7]  = '{3'd7, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0, 5'd8,  1'b1};
    v[8]  = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 5'd9,  1'b1};
    v[9]  = '{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b1};
    v[10] = '{3'd5, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1'b1, 5'd11, 1'b1};
    v[11] = '{3'd6, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1, 5'd12, 1'b1};
    v[12] = '{3'd7, 32'h00001234, 32'h00000000, 32'h00001234, 1'b1, 5'd13, 1'b1};
    v[13] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 5'd14, 1'b1};
    v[14] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 5'd15, 1'b1};
    v[15] = '{3'd4, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000001, 1'b0, 5'd16, 1'b1};
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].wd, v[i].wreg);
      e1 = v[i].fast ? 1 : N1 + 2;
      e4 = v[i].fast ? 1 : N4 + 2;
      checks++; if (res1 !== v[i].exp) begin failures++; $display("[TB] FAIL div[%0d] data bpc1: got %h want %h", i, res1, v[i].exp); end
      checks++; if (res4 !== v[i].exp) begin failures++; $display("[TB] FAIL div[%0d] data bpc4: got %h want %h", i, res4, v[i].exp); end
      checks++; if (lat1 != e1) begin failures++; $display("[TB] FAIL div[%0d] latency bpc1: got %0d want %0d", i, lat1, e1); end
      checks++; if (lat4 != e4) begin failures++; $display("[TB] FAIL div[%0d] latency bpc4: got %0d want %0d", i, lat4, e4); end
      checks++; if (stl1 != e1) begin failures++; $display("[TB] FAIL div[%0d] stall bpc1: got %0d want %0d", i, stl1, e1); end
      checks++; if (stl4 != e4) begin failures++; $display("[TB] FAIL div[%0d] stall bpc4: got %0d want %0d", i, stl4, e4); end
      checks++; if (wro1 !== 1'b1) begin failures++; $display("[TB] FAIL div[%0d] wreg bpc1: got %b want 1", i, wro1); end
      checks++; if (wdo4 !== v[i].wd) begin failures++; $display("[TB] FAIL div[%0d] wd bpc4: got %0d want %0d", i, wdo4, v[i].wd); end
      checks++; if (pls1 != 1) begin failures++; $display("[TB] FAIL div[%0d] pulses bpc1: got %0d want 1", i, pls1); end
      checks++; if (pls4 != 1) begin failures++; $display("[TB] FAIL div[%0d] pulses bpc4: got %0d want 1", i, pls4); end
    end
  endtask

  task automatic test_flush();
    int dones;
    // Abort a 1-bit-per-cycle multiply in its tenth CALC cycle.
    @(negedge clk);
    op = 3'd0; reg1 = 32'h7; reg2 = 32'hFFFFFFFD; wd = 5'd3; wreg = 1'b1; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    #1;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL flush_calc_busy_before: got %b want 1", busy1); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL flush_calc_busy_after: got %b want 0", busy1); end
    checks++; if (stall1 !== 1'b0) begin failures++; $display("[TB] FAIL flush_calc_stall_after: got %b want 0", stall1); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done1) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("[TB] FAIL flush_calc_no_done: got %0d pulses want 0", dones); end
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1);
    checks++; if (res1 !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL flush_recover_data bpc1: got %h want fffffffe", res1); end
    checks++; if (lat1 != N1 + 2) begin failures++; $display("[TB] FAIL flush_recover_latency bpc1: got %0d want %0d", lat1, N1 + 2); end
    checks++; if (res4 !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL flush_recover_data bpc4: got %h want fffffffe", res4); end

    // Flush in the same cycle as start: the op must not be accepted.
    @(negedge clk);
    op = 3'd5; reg1 = 32'd100; reg2 = 32'd7; wd = 5'd9; wreg = 1'b1; start = 1'b1; flush = 1'b1;
    #1;
    checks++; if ({stall1, stall4} !== 2'b00) begin failures++; $display("[TB] FAIL flush_start_stall: got %b%b want 00", stall1, stall4); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if ({busy1, busy4} !== 2'b00) begin failures++; $display("[TB] FAIL flush_start_busy: got %b%b want 00", busy1, busy4); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done1 || done4) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("[TB] FAIL flush_start_no_done: got %0d pulses want 0", dones); end
    checks++; if (wdata1 !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL flush_start_wdata_hold: got %h want fffffffe", wdata1); end
  endtask

  task automatic test_busy_ignore();
    int p1, p4, l1, l4;
    logic [31:0] r1, r4;
    logic [4:0]  w1;
    p1 = 0; p4 = 0; l1 = -1; l4 = -1; r1 = '0; r4 = '0; w1 = '0;
    @(negedge clk);
    op = 3'd0; reg1 = 32'h7; reg2 = 32'hFFFFFFFD; wd = 5'd9; wreg = 1'b1; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) begin
        op = 3'd5; reg1 = 32'd100; reg2 = 32'd7; wd = 5'd10; start = 1'b1;
      end
      #1;
      if (k == 5) begin
        checks++; if ({stall1, stall4} !== 2'b11) begin failures++; $display("[TB] FAIL busy_stall: got %b%b want 11", stall1, stall4); end
      end
      if (done1) begin p1++; if (l1 < 0) begin l1 = k; r1 = wdata1; w1 = wd1_o; end end
      if (done4) begin p4++; if (l4 < 0) begin l4 = k; r4 = wdata4; end end
    end
    checks++; if (p1 != 1) begin failures++; $display("[TB] FAIL busy_pulses bpc1: got %0d want 1", p1); end
    checks++; if (p4 != 1) begin failures++; $display("[TB] FAIL busy_pulses bpc4: got %0d want 1", p4); end
    checks++; if (r1 !== 32'hFFFFFFEB) begin failures++; $display("[TB] FAIL busy_data bpc1: got %h want ffffffeb", r1); end
    checks++; if (r4 !== 32'hFFFFFFEB) begin failures++; $display("[TB] FAIL busy_data bpc4: got %h want ffffffeb", r4); end
    checks++; if (w1 !== 5'd9) begin failures++; $display("[TB] FAIL busy_wd bpc1: got %0d want 9", w1); end
    checks++; if (l1 != N1 + 2) begin failures++; $display("[TB] FAIL busy_latency bpc1: got %0d want %0d", l1, N1 + 2); end
    checks++; if (l4 != N4 + 2) begin failures++; $display("[TB] FAIL busy_latency bpc4: got %0d want %0d", l4, N4 + 2); end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    op = 3'd5; reg1 = 32'd100; reg2 = 32'd7; wd = 5'd11; wreg = 1'b1; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if ({busy1, busy4} !== 2'b11) begin failures++; $display("[TB] FAIL rst_mid_busy_before: got %b%b want 11", busy1, busy4); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy1, stall1, done1, wreg1_o, wd1_o, wdata1} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_bpc1: got busy=%b stall=%b done=%b wreg=%b wd=%h wdata=%h want all zero",
               busy1, stall1, done1, wreg1_o, wd1_o, wdata1);
    end
    checks++;
    if ({busy4, stall4, done4, wreg4_o, wd4_o, wdata4} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_bpc4: got busy=%b stall=%b done=%b wreg=%b wd=%h wdata=%h want all zero",
               busy4, stall4, done4, wreg4_o, wd4_o, wdata4);
    end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done1 || done4) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("[TB] FAIL rst_mid_no_done: got %0d pulses want 0", dones); end
    run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd12, 1'b1);
    checks++; if (res1 !== 32'hFFFFFFFD) begin failures++; $display("[TB] FAIL rst_recover_data bpc1: got %h want fffffffd", res1); end
    checks++; if (res4 !== 32'hFFFFFFFD) begin failures++; $display("[TB] FAIL rst_recover_data bpc4: got %h want fffffffd", res4); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_flush();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
